// File: rtl/life_ctrl_if.sv
// Bundle of key, cursor, board-port and engine signals around life_ctrl.
// Engine handshake: gen_start is a one-cycle request pulse from the controller;
// gen_done is a one-cycle completion pulse from the engine. gen_done counts only
// while a generation is outstanding and not in the same cycle as its gen_start.
interface life_ctrl_if #(
    parameter int LOG2X = 3,
    parameter int LOG2Y = 3
);
    logic             key_toggle;
    logic             key_run;
    logic             key_step;
    logic             key_clear;
    logic [LOG2X-1:0] cursor_x;
    logic [LOG2Y-1:0] cursor_y;
    logic             cell_rd;
    logic [LOG2X-1:0] cell_x;
    logic [LOG2Y-1:0] cell_y;
    logic             cell_we;
    logic             cell_wdata;
    logic             gen_start;
    logic             gen_done;
    logic             running;
    logic [15:0]      gen_count;

    modport master (
        input  key_toggle, key_run, key_step, key_clear,
        input  cursor_x, cursor_y, cell_rd, gen_done,
        output cell_x, cell_y, cell_we, cell_wdata,
        output gen_start, running, gen_count
    );

    modport slave (
        output key_toggle, key_run, key_step, key_clear,
        output cursor_x, cursor_y, cell_rd, gen_done,
        input  cell_x, cell_y, cell_we, cell_wdata,
        input  gen_start, running, gen_count
    );
endinterface

// File: rtl/life_ctrl.sv
// Life board mode controller: edit-mode toggle/clear, paced run mode, and
// single-owner board write port so edits and generations never collide.
module life_ctrl #(
    parameter int              X      = 8,
    parameter int              Y      = 8,
    parameter int              LOG2X  = 3,
    parameter int              LOG2Y  = 3,
    parameter int              RATE_W = 24,
    parameter logic [RATE_W-1:0] RATE = 24'd5000000
) (
    input  logic        clk,
    input  logic        reset,
    life_ctrl_if.master bus,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TOGGLE   = 3'd1,
        CLEAR    = 3'd2,
        RUN_WAIT = 3'd3,
        GEN      = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        kd_q, kd_d;
    logic [RATE_W-1:0] cnt_q, cnt_d;
    logic [LOG2X-1:0]  tx_q, tx_d, cx_q, cx_d;
    logic [LOG2Y-1:0]  ty_q, ty_d, cy_q, cy_d;
    logic              twd_q, twd_d;
    logic [15:0]       gen_count_q, gen_count_d;
    logic              running_q, running_d;
    logic              stop_req_q, stop_req_d;
    logic              gen_start_q, gen_start_d;

    // Keys packed as {clear, run, step, toggle}; an event is a release.
    logic [3:0] keys;
    logic [3:0] ev;
    logic       ev_clear, ev_run, ev_step, ev_toggle;
    logic       done_ok;

    assign keys      = {bus.key_clear, bus.key_run, bus.key_step, bus.key_toggle};
    assign ev        = kd_q & ~keys;
    assign ev_clear  = ev[3];
    assign ev_run    = ev[2];
    assign ev_step   = ev[1];
    assign ev_toggle = ev[0];
    // The gen_start cycle cannot also complete the generation it launches.
    assign done_ok   = bus.gen_done & ~gen_start_q;

    // State and datapath registers, all cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            kd_q        <= '0;
            cnt_q       <= '0;
            tx_q        <= '0;
            ty_q        <= '0;
            twd_q       <= 1'b0;
            cx_q        <= '0;
            cy_q        <= '0;
            gen_count_q <= '0;
            running_q   <= 1'b0;
            stop_req_q  <= 1'b0;
            gen_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            kd_q        <= kd_d;
            cnt_q       <= cnt_d;
            tx_q        <= tx_d;
            ty_q        <= ty_d;
            twd_q       <= twd_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            gen_count_q <= gen_count_d;
            running_q   <= running_d;
            stop_req_q  <= stop_req_d;
            gen_start_q <= gen_start_d;
        end
    end

    // Next-state logic: event priority and per-state sequencing.
    always_comb begin
        state_d     = state_q;
        kd_d        = keys;
        cnt_d       = cnt_q;
        tx_d        = tx_q;
        ty_d        = ty_q;
        twd_d       = twd_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        gen_count_d = gen_count_q;
        running_d   = running_q;
        stop_req_d  = stop_req_q;
        gen_start_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (ev_clear) begin
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = CLEAR;
                end else if (ev_run) begin
                    running_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = RUN_WAIT;
                end else if (ev_step) begin
                    gen_start_d = 1'b1;
                    stop_req_d  = 1'b0;
                    state_d     = GEN;
                end else if (ev_toggle) begin
                    tx_d    = bus.cursor_x;
                    ty_d    = bus.cursor_y;
                    twd_d   = ~bus.cell_rd;
                    state_d = TOGGLE;
                end
            end

            TOGGLE: begin
                state_d = IDLE;
            end

            CLEAR: begin
                if (cx_q == LOG2X'(X - 1)) begin
                    cx_d = '0;
                    if (cy_q == LOG2Y'(Y - 1)) begin
                        cy_d        = '0;
                        gen_count_d = '0;
                        running_d   = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        cy_d = cy_q + LOG2Y'(1);
                    end
                end else begin
                    cx_d = cx_q + LOG2X'(1);
                end
            end

            RUN_WAIT: begin
                if (ev_clear) begin
                    running_d = 1'b0;
                    cx_d      = '0;
                    cy_d      = '0;
                    state_d   = CLEAR;
                end else if (ev_run) begin
                    running_d = 1'b0;
                    state_d   = IDLE;
                end else if (cnt_q == RATE - RATE_W'(1)) begin
                    gen_start_d = 1'b1;
                    stop_req_d  = 1'b0;
                    state_d     = GEN;
                end else begin
                    cnt_d = cnt_q + RATE_W'(1);
                end
            end

            GEN: begin
                if (ev_run) begin
                    stop_req_d = 1'b1;
                end
                if (done_ok) begin
                    gen_count_d = gen_count_q + 16'd1;
                    // A stop request raised in the completing cycle still counts.
                    if (running_q && !(stop_req_q || ev_run)) begin
                        cnt_d      = '0;
                        stop_req_d = 1'b0;
                        state_d    = RUN_WAIT;
                    end else begin
                        running_d  = 1'b0;
                        stop_req_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Board port: only TOGGLE and CLEAR write; otherwise address follows the cursor.
    always_comb begin
        bus.cell_x     = bus.cursor_x;
        bus.cell_y     = bus.cursor_y;
        bus.cell_we    = 1'b0;
        bus.cell_wdata = 1'b0;
        case (state_q)
            TOGGLE: begin
                bus.cell_x     = tx_q;
                bus.cell_y     = ty_q;
                bus.cell_we    = 1'b1;
                bus.cell_wdata = twd_q;
            end
            CLEAR: begin
                bus.cell_x     = cx_q;
                bus.cell_y     = cy_q;
                bus.cell_we    = 1'b1;
                bus.cell_wdata = 1'b0;
            end
            default: begin
                bus.cell_we = 1'b0;
            end
        endcase
    end

    assign bus.gen_start = gen_start_q;
    assign bus.running   = running_q;
    assign bus.gen_count = gen_count_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_life_ctrl.sv
// Directed bench for life_ctrl with RATE=4: expected writes, gen_start cycles
// and running/gen_count changes are predicted from the timing rules and
// compared against the DUT on every cycle.
module tb_life_ctrl;

    localparam logic [3:0] K_TOG  = 4'b0001;
    localparam logic [3:0] K_STEP = 4'b0010;
    localparam logic [3:0] K_RUN  = 4'b0100;
    localparam logic [3:0] K_CLR  = 4'b1000;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        reset;
    logic [31:0] cyc;
    logic [3:0]  keys;
    logic [2:0]  dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    life_ctrl_if #(.LOG2X(3), .LOG2Y(3)) bus ();

    assign bus.key_toggle = keys[0];
    assign bus.key_step   = keys[1];
    assign bus.key_run    = keys[2];
    assign bus.key_clear  = keys[3];

    life_ctrl #(
        .X(8), .Y(8), .LOG2X(3), .LOG2Y(3), .RATE_W(24), .RATE(24'd4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_cmp;
    int n_bad;
    logic [38:0] wr_q[$];   // {cycle, x, y, wdata}
    logic [31:0] gs_q[$];   // cycles with gen_start high
    logic [48:0] st_q[$];   // {cycle, running, gen_count} taking effect that cycle
    logic        m_run;
    logic [15:0] m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic push_wr(input logic [31:0] c, input logic [2:0] x, input logic [2:0] y, input logic d);
        wr_q.push_back({c, x, y, d});
    endtask

    task automatic push_st(input logic [31:0] c, input logic r, input logic [15:0] n);
        st_q.push_back({c, r, n});
    endtask

    // Per-cycle compare against the predicted behaviour.
    always @(negedge clk) begin
        if (!reset) begin
            logic [38:0] e;
            logic [31:0] g;
            while (st_q.size() > 0 && st_q[0][48:17] <= cyc) begin
                m_run = st_q[0][16];
                m_cnt = st_q[0][15:0];
                void'(st_q.pop_front());
            end
            chk("running", 64'(bus.running), 64'(m_run));
            chk("gen_count", 64'(bus.gen_count), 64'(m_cnt));

            if (bus.cell_we) begin
                e = (wr_q.size() > 0) ? wr_q.pop_front() : '1;
                chk("write", 64'({cyc, bus.cell_x, bus.cell_y, bus.cell_wdata}), 64'(e));
            end else begin
                if (wr_q.size() > 0 && wr_q[0][38:7] <= cyc) begin
                    chk("cell_we", 64'(bus.cell_we), 64'd1);
                    void'(wr_q.pop_front());
                end
                chk("cell_xy_cursor", 64'({bus.cell_x, bus.cell_y}), 64'({bus.cursor_x, bus.cursor_y}));
            end

            if (bus.gen_start) begin
                g = (gs_q.size() > 0) ? gs_q.pop_front() : '1;
                chk("gen_start_cycle", 64'(cyc), 64'(g));
            end else if (gs_q.size() > 0 && gs_q[0] <= cyc) begin
                chk("gen_start", 64'(bus.gen_start), 64'd1);
                void'(gs_q.pop_front());
            end
        end
    end

    // ---------------- engine responder: gen_done 3 cycles after gen_start ----------------
    initial begin
        logic        pend;
        logic [31:0] done_at;
        pend = 1'b0;
        done_at = '0;
        bus.gen_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.gen_done = 1'b0;
            if (pend && cyc == done_at) begin
                bus.gen_done = 1'b1;
                pend = 1'b0;
            end
            if (bus.gen_start && !reset) begin
                pend = 1'b1;
                done_at = cyc + 32'd3;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_until(input logic [31:0] c);
        while (cyc < c) @(negedge clk);
    endtask

    // Press during cycle c-1, release in cycle c: the event is seen in cycle c.
    task automatic release_at(input logic [3:0] mask, input logic [31:0] c);
        wait_until(c - 32'd1);
        keys = keys | mask;
        wait_until(c);
        keys = keys & ~mask;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] c;
        logic [31:0] e;
        n_cmp = 0;
        n_bad = 0;
        m_run = 1'b0;
        m_cnt = '0;
        cyc   = '0;
        keys  = '0;
        reset = 1'b1;
        bus.cursor_x = 3'd2;
        bus.cursor_y = 3'd6;
        bus.cell_rd  = 1'b0;

        // Reset values
        #12;
        chk("rst_cell_we", 64'(bus.cell_we), 64'd0);
        chk("rst_cell_wdata", 64'(bus.cell_wdata), 64'd0);
        chk("rst_gen_start", 64'(bus.gen_start), 64'd0);
        chk("rst_running", 64'(bus.running), 64'd0);
        chk("rst_gen_count", 64'(bus.gen_count), 64'd0);
        chk("rst_cell_x", 64'(bus.cell_x), 64'd2);
        chk("rst_cell_y", 64'(bus.cell_y), 64'd6);
        @(negedge clk);
        reset = 1'b0;

        // Toggle at (3,5) with cell_rd=0 -> one write of 1
        bus.cursor_x = 3'd3;
        bus.cursor_y = 3'd5;
        c = cyc + 32'd3;
        release_at(K_TOG, c);
        push_wr(c + 32'd1, 3'd3, 3'd5, 1'b1);
        wait_until(c + 32'd1);
        chk("tog1_we", 64'(bus.cell_we), 64'd1);
        chk("tog1_xy", 64'({bus.cell_x, bus.cell_y}), 64'({3'd3, 3'd5}));
        chk("tog1_wdata", 64'(bus.cell_wdata), 64'd1);

        // Toggle again with cell_rd=1 -> write of 0
        bus.cell_rd = 1'b1;
        c = cyc + 32'd3;
        release_at(K_TOG, c);
        push_wr(c + 32'd1, 3'd3, 3'd5, 1'b0);
        wait_until(c + 32'd1);
        chk("tog2_wdata", 64'(bus.cell_wdata), 64'd0);
        bus.cell_rd = 1'b0;

        // Single step: gen_start next cycle, count 1 after gen_done, running stays 0
        c = cyc + 32'd3;
        release_at(K_STEP, c);
        gs_q.push_back(c + 32'd1);
        push_st(c + 32'd5, 1'b0, 16'd1);
        wait_until(c + 32'd8);
        chk("step_count", 64'(bus.gen_count), 64'd1);

        // Clear together with toggle: only the 64-cell sweep, count back to 0
        c = cyc + 32'd3;
        release_at(K_CLR | K_TOG, c);
        for (int i = 0; i < 64; i++) push_wr(c + 32'd1 + 32'(i), 3'(i % 8), 3'(i / 8), 1'b0);
        push_st(c + 32'd65, 1'b0, 16'd0);
        wait_until(c + 32'd66);
        chk("clr_done_we", 64'(bus.cell_we), 64'd0);
        chk("clr_count", 64'(bus.gen_count), 64'd0);

        // Run mode: gen_start at E+4, E+12, E+20; stop request in the third GEN
        c = cyc + 32'd3;
        e = c + 32'd1;
        push_st(e, 1'b1, 16'd0);
        push_st(e + 32'd8, 1'b1, 16'd1);
        push_st(e + 32'd16, 1'b1, 16'd2);
        push_st(e + 32'd24, 1'b0, 16'd3);
        gs_q.push_back(e + 32'd4);
        gs_q.push_back(e + 32'd12);
        gs_q.push_back(e + 32'd20);
        release_at(K_RUN, c);
        wait_until(e + 32'd4);
        chk("run_gs1", 64'(bus.gen_start), 64'd1);
        // Toggle and step releases inside RUN_WAIT are dropped
        release_at(K_TOG, e + 32'd9);
        release_at(K_STEP, e + 32'd10);
        release_at(K_RUN, e + 32'd21);
        wait_until(e + 32'd40);
        chk("run_stop_running", 64'(bus.running), 64'd0);
        chk("run_stop_count", 64'(bus.gen_count), 64'd3);

        // Reset in the middle of a clear sweep (cycle 20 of the sweep)
        c = cyc + 32'd3;
        e = c + 32'd1;
        for (int i = 0; i < 20; i++) push_wr(e + 32'(i), 3'(i % 8), 3'(i / 8), 1'b0);
        release_at(K_CLR, c);
        wait_until(e + 32'd19);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_we", 64'(bus.cell_we), 64'd0);
        chk("mid_rst_wdata", 64'(bus.cell_wdata), 64'd0);
        chk("mid_rst_gen_start", 64'(bus.gen_start), 64'd0);
        chk("mid_rst_running", 64'(bus.running), 64'd0);
        chk("mid_rst_count", 64'(bus.gen_count), 64'd0);
        chk("mid_rst_xy", 64'({bus.cell_x, bus.cell_y}), 64'({bus.cursor_x, bus.cursor_y}));
        chk("mid_rst_pending_writes", 64'(wr_q.size()), 64'd0);
        wr_q.delete();
        m_run = 1'b0;
        m_cnt = 16'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Toggle after reset behaves normally
        bus.cursor_x = 3'd6;
        bus.cursor_y = 3'd1;
        c = cyc + 32'd3;
        release_at(K_TOG, c);
        push_wr(c + 32'd1, 3'd6, 3'd1, 1'b1);
        wait_until(c + 32'd1);
        chk("post_rst_tog_we", 64'(bus.cell_we), 64'd1);
        chk("post_rst_tog_xy", 64'({bus.cell_x, bus.cell_y}), 64'({3'd6, 3'd1}));
        wait_until(c + 32'd6);

        chk("left_writes", 64'(wr_q.size()), 64'd0);
        chk("left_gen_starts", 64'(gs_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/life_ctrl.md
# life_ctrl

Mode controller and board-access sequencer for the Life board. It sits between the key inputs and cursor position on one side and the board storage and generation engine on the other. In edit mode it toggles and clears cells. In run mode it paces generations at a programmable rate and owns the single board write port, so edits and generations never collide.

## Interface
- X, 8, board width in cells
- Y, 8, board height in cells
- LOG2X, 3, width of x coordinates
- LOG2Y, 3, width of y coordinates
- RATE_W, 24, width of the rate counter
- RATE, 24'd5000000, clock cycles spent in RUN_WAIT per generation; minimum 1

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; all state and outputs go to reset values
- key_toggle, key_run, key_step, key_clear  in  1 each  raw key levels, active-high
- cursor_x  in  LOG2X  cursor column
- cursor_y  in  LOG2Y  cursor row
- cell_rd  in  1  board value at (cell_x, cell_y), combinational from storage
- cell_x  out  LOG2X  board access column
- cell_y  out  LOG2Y  board access row
- cell_we  out  1  board write strobe
- cell_wdata  out  1  board write data
- gen_start  out  1  one-cycle pulse that launches one generation
- gen_done  in  1  one-cycle pulse when a generation has completed
- running  out  1  run mode active
- gen_count  out  16  generations completed since reset or clear

## Operation
- Key events:
  - Each key is registered once (kd <= key; reset value 0).
  - An event is a release, kd & ~key, seen in the same cycle.
  - Events are only acted on in the states listed below; in any other state they are dropped.
- States: IDLE, TOGGLE, CLEAR, RUN_WAIT, GEN. Reset state is IDLE.
- IDLE (edit mode):
  - cell_x/cell_y follow cursor_x/cursor_y combinationally.
  - Event priority: clear > run > step > toggle. Simultaneous lower-priority events are dropped.
  - clear -> CLEAR.
  - run -> running=1, rate counter=0, go to RUN_WAIT.
  - step -> GEN with gen_start, running stays 0.
  - toggle -> latch the cursor as (tx,ty) and latch ~cell_rd, go to TOGGLE.
- TOGGLE: one cycle with cell_we=1, cell_x/cell_y=(tx,ty), cell_wdata=latched value. Then IDLE.
- CLEAR:
  - Sweep all X*Y cells, one per cycle, row-major: y outer, x inner, from (0,0) to (X-1,Y-1).
  - cell_we=1 and cell_wdata=0 throughout.
  - The last cycle returns to IDLE with gen_count=0 and running=0.
- RUN_WAIT:
  - The rate counter increments each cycle.
  - When counter==RATE-1, go to GEN with gen_start.
  - run event -> running=0, go to IDLE.
  - clear event -> running=0, go to CLEAR.
  - step and toggle events are dropped.
- GEN:
  - cell_we=0. cell_x/cell_y follow the cursor; the engine owns the board.
  - A run event sets stop_req; all other events are dropped.
  - gen_done is accepted on any GEN cycle after the gen_start cycle. On acceptance gen_count increments (wraps at 16 bits).
  - After acceptance: if running & ~stop_req, counter=0 and go to RUN_WAIT. Otherwise running=0, stop_req=0, go to IDLE.
  - gen_done outside GEN, or in the gen_start cycle, is ignored.
- Mid-operation reset: state returns to IDLE immediately and asynchronously. A partial CLEAR or an in-flight generation is abandoned; the board is not restored.

## Timing
- Reset values: cell_we=0, cell_wdata=0, gen_start=0, running=0, gen_count=0, state IDLE. cell_x/cell_y equal the cursor.
- Toggle: release sampled at edge n -> TOGGLE at cycle n+1 with cell_we=1 -> IDLE at n+2.
- Clear: release at edge n -> cell_we high for cycles n+1 .. n+X*Y -> IDLE at n+X*Y+1.
- Run: release at edge n -> RUN_WAIT at n+1 -> gen_start high in cycle n+RATE+1. Later gen_start pulses come RATE+1 cycles after each accepted gen_done.
- Step: release at edge n -> gen_start high in cycle n+1.
- gen_start is registered, high for exactly one cycle, and is the first cycle of GEN.
- Throughput: one board write per cycle at most. cell_we is never high in RUN_WAIT or GEN.

## Test plan
- Reset with RATE=4, then toggle release at cursor (3,5) with cell_rd=0 -> exactly one cell_we cycle at (3,5), wdata=1. Repeat with cell_rd=1 -> wdata=0.
- clear release -> 64 consecutive cell_we cycles with wdata=0, addresses (0,0),(1,0)..(7,7), then IDLE with gen_count=0.
- run release, engine returns gen_done 3 cycles after each gen_start -> gen_start pulses spaced 4+1+3=8 cycles apart. gen_count goes 1, 2, 3 over three generations.
- run release during GEN -> the current generation completes, gen_count increments once, running=0, and no further gen_start.
- Same-cycle releases of clear and toggle in IDLE -> only the clear sweep occurs. Toggle and step releases during RUN_WAIT -> no write and no extra gen_start.
- reset asserted at CLEAR cycle 20 -> outputs take reset values immediately. After release, a toggle behaves normally.
